// File: rtl/countdown_timer_bcd_if.sv
// Control/status bundle between the top-level game FSM and the BCD countdown timer.
// The FSM side is the master; the timer is the slave.
interface countdown_timer_bcd_if #(
   parameter int DIGITS  = 2,
   parameter int STATE_W = 4
);
   logic [STATE_W-1:0]  state;
   logic                load;
   logic [4*DIGITS-1:0] load_val;
   logic [4*DIGITS-1:0] digits;
   logic                flag;
   logic                done_pulse;
   logic                tick;
   logic                running;

   modport master (
      output state, load, load_val,
      input  digits, flag, done_pulse, tick, running
   );

   modport slave (
      input  state, load, load_val,
      output digits, flag, done_pulse, tick, running
   );
endinterface

// File: rtl/countdown_timer_bcd.sv
// Multi-digit BCD countdown timer, decrementing once per prescaler period
// while the top-level FSM is in ACTIVE_STATE; raises a sticky flag at zero.
module countdown_timer_bcd #(
   parameter int                 CLK_HZ       = 50_000_000,
   parameter int                 TICK_HZ      = 1,
   parameter int                 DIGITS       = 2,
   parameter int                 START_VAL    = 10,
   parameter int                 STATE_W      = 4,
   parameter logic [STATE_W-1:0] ACTIVE_STATE = STATE_W'(4'b1011)
) (
   input  logic                        clk,
   input  logic                        rst,
   countdown_timer_bcd_if.slave        bus
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);

   logic [4*DIGITS-1:0] count_reg;
   logic [PW-1:0]       presc_reg;
   logic                flag_reg;
   logic                done_reg;
   logic                tick_reg;

   logic [4*DIGITS-1:0] start_bcd;
   logic [4*DIGITS-1:0] clamped;
   logic [4*DIGITS-1:0] dec_next;
   logic [DIGITS:0]     borrow;
   logic                active;
   logic                wrap;

   assign active    = (bus.state == ACTIVE_STATE);
   assign wrap      = (presc_reg == PW'(DIV - 1));
   assign borrow[0] = 1'b1;

   // Per digit: constant reset value, input clamp, and one stage of the borrow chain.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic digit_zero;
         assign start_bcd[4*gi +: 4] = 4'((START_VAL / (10 ** gi)) % 10);
         assign clamped[4*gi +: 4]   = (bus.load_val[4*gi +: 4] > 4'd9) ? 4'd9
                                                                        : bus.load_val[4*gi +: 4];
         assign digit_zero           = (count_reg[4*gi +: 4] == 4'd0);
         assign dec_next[4*gi +: 4]  = !borrow[gi] ? count_reg[4*gi +: 4] :
                                       digit_zero  ? 4'd9 : count_reg[4*gi +: 4] - 4'd1;
         assign borrow[gi+1]         = borrow[gi] & digit_zero;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= start_bcd;
         presc_reg <= '0;
         flag_reg  <= 1'b0;
         done_reg  <= 1'b0;
         tick_reg  <= 1'b0;
      end else if (bus.load) begin
         count_reg <= clamped;
         presc_reg <= '0;
         flag_reg  <= (clamped == '0);
         done_reg  <= 1'b0;
         tick_reg  <= 1'b0;
      end else if (active) begin
         tick_reg  <= wrap;
         presc_reg <= wrap ? '0 : presc_reg + PW'(1);
         done_reg  <= 1'b0;
         // A count already at zero holds: no wrap-around and no repeat done_pulse.
         if (wrap && (count_reg != '0)) begin
            count_reg <= dec_next;
            if (dec_next == '0) begin
               flag_reg <= 1'b1;
               done_reg <= 1'b1;
            end
         end
      end else begin
         tick_reg <= 1'b0;
         done_reg <= 1'b0;
      end
   end

   assign bus.digits     = count_reg;
   assign bus.flag       = flag_reg;
   assign bus.done_pulse = done_reg;
   assign bus.tick       = tick_reg;
   assign bus.running    = active && !flag_reg;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd: a 2-digit and a 3-digit instance at DIV=4,
// expectations queued per step and compared against the outputs just after each edge.
module tb_countdown_timer_bcd;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   countdown_timer_bcd_if #(.DIGITS(2), .STATE_W(4)) a_if ();
   countdown_timer_bcd_if #(.DIGITS(3), .STATE_W(4)) b_if ();

   countdown_timer_bcd #(
      .CLK_HZ(4), .TICK_HZ(1), .DIGITS(2), .START_VAL(10),
      .STATE_W(4), .ACTIVE_STATE(4'b1011)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(a_if.slave)
   );

   countdown_timer_bcd #(
      .CLK_HZ(4), .TICK_HZ(1), .DIGITS(3), .START_VAL(100),
      .STATE_W(4), .ACTIVE_STATE(4'b1011)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(b_if.slave)
   );

   // Observation word: {digits, flag, done_pulse, tick, running}
   logic [15:0] obs_a;
   logic [15:0] obs_b;
   assign obs_a = {4'h0, a_if.digits, a_if.flag, a_if.done_pulse, a_if.tick, a_if.running};
   assign obs_b = {b_if.digits, b_if.flag, b_if.done_pulse, b_if.tick, b_if.running};

   typedef struct {
      string       tag;
      bit          sel;
      logic [15:0] exp;
   } sb_t;

   sb_t sb[$];
   int  vectors     = 0;
   int  miscompares = 0;

   task automatic push_a(string tag, logic [7:0] d, logic f, logic p, logic t, logic r);
      sb_t e;
      e.tag = tag; e.sel = 1'b0; e.exp = {4'h0, d, f, p, t, r};
      sb.push_back(e);
   endtask

   task automatic push_b(string tag, logic [11:0] d, logic f, logic p, logic t, logic r);
      sb_t e;
      e.tag = tag; e.sel = 1'b1; e.exp = {d, f, p, t, r};
      sb.push_back(e);
   endtask

   task automatic step_drain();
      sb_t         e;
      logic [15:0] obs;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = e.sel ? obs_b : obs_a;
         vectors++;
         assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed {digits,f,d,t,r}=%h expected %h", e.tag, obs, e.exp);
         end
         $display("vec %0d %s: observed %h expected %h", vectors, e.tag, obs, e.exp);
      end
   endtask

   task automatic ca(string tag, logic [7:0] d, logic f, logic p, logic t, logic r);
      push_a(tag, d, f, p, t, r);
      step_drain();
   endtask

   task automatic cb(string tag, logic [11:0] d, logic f, logic p, logic t, logic r);
      push_b(tag, d, f, p, t, r);
      step_drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_if.state = 4'b0000; a_if.load = 1'b0; a_if.load_val = 8'h00;
      b_if.state = 4'b0000; b_if.load = 1'b0; b_if.load_val = 12'h000;

      push_a("reset_a", 8'h10, 0, 0, 0, 0);
      push_b("reset_b", 12'h100, 0, 0, 0, 0);
      step_drain();

      // Free run from reset down to zero, then hold at zero.
      rst = 1'b0;
      a_if.state = 4'b1011;
      for (int k = 0; k < 3; k++) ca("pre_first_tick", 8'h10, 0, 0, 0, 1);
      ca("first_dec", 8'h09, 0, 0, 1, 1);
      for (int v = 9; v >= 1; v--) begin
         for (int k = 0; k < 3; k++) ca("hold", 8'(v), 0, 0, 0, 1);
         ca("dec", 8'(v - 1), v == 1, v == 1, 1, v != 1);
      end
      for (int k = 0; k < 8; k++) ca("expired_hold", 8'h00, 1, 0, (k % 4) == 3, 0);

      // BCD borrow and digit clamp.
      a_if.load = 1'b1; a_if.load_val = 8'h20;
      ca("load_20", 8'h20, 0, 0, 0, 1);
      a_if.load = 1'b0;
      for (int k = 0; k < 3; k++) ca("hold_20", 8'h20, 0, 0, 0, 1);
      ca("borrow_19", 8'h19, 0, 0, 1, 1);
      a_if.load = 1'b1; a_if.load_val = 8'h9F;
      ca("clamp_99", 8'h99, 0, 0, 0, 1);
      a_if.load = 1'b0;

      // State gating: pause mid-period and resume without losing cycles.
      for (int k = 0; k < 6; k++) ca("gate_run", (k < 3) ? 8'h99 : 8'h98, 0, 0, k == 3, 1);
      a_if.state = 4'b0000;
      for (int k = 0; k < 10; k++) ca("gate_frozen", 8'h98, 0, 0, 0, 0);
      a_if.state = 4'b1011;
      ca("resume_1", 8'h98, 0, 0, 0, 1);
      ca("resume_2", 8'h97, 0, 0, 1, 1);

      // Zero load: flag without done_pulse, then a nonzero load clears it.
      a_if.load = 1'b1; a_if.load_val = 8'h00;
      ca("zero_load", 8'h00, 1, 0, 0, 0);
      a_if.load = 1'b0;
      for (int k = 0; k < 8; k++) ca("zero_hold", 8'h00, 1, 0, (k % 4) == 3, 0);
      a_if.load = 1'b1; a_if.load_val = 8'h05;
      ca("load_05", 8'h05, 0, 0, 0, 1);
      a_if.load = 1'b0;
      for (int k = 0; k < 3; k++) ca("hold_05", 8'h05, 0, 0, 0, 1);
      ca("dec_04", 8'h04, 0, 0, 1, 1);

      // Load on the wrap cycle wins over the decrement.
      for (int k = 0; k < 3; k++) ca("pre_wrap", 8'h04, 0, 0, 0, 1);
      a_if.load = 1'b1; a_if.load_val = 8'h42;
      ca("load_wins", 8'h42, 0, 0, 0, 1);
      a_if.load = 1'b0;
      for (int k = 0; k < 3; k++) ca("hold_42", 8'h42, 0, 0, 0, 1);
      ca("dec_41", 8'h41, 0, 0, 1, 1);

      // Reset overrides a simultaneous load mid-period.
      for (int k = 0; k < 2; k++) ca("mid_period", 8'h41, 0, 0, 0, 1);
      rst = 1'b1; a_if.load = 1'b1; a_if.load_val = 8'h77;
      push_a("rst_wins_a", 8'h10, 0, 0, 0, 1);
      push_b("rst_wins_b", 12'h100, 0, 0, 0, 0);
      step_drain();
      rst = 1'b0; a_if.load = 1'b0;
      for (int k = 0; k < 3; k++) ca("post_rst", 8'h10, 0, 0, 0, 1);
      ca("post_rst_dec", 8'h09, 0, 0, 1, 1);

      // Three-digit instance: 100 -> 099 -> 098.
      b_if.state = 4'b1011;
      for (int k = 0; k < 3; k++) cb("b_hold_100", 12'h100, 0, 0, 0, 1);
      cb("b_dec_099", 12'h099, 0, 0, 1, 1);
      for (int k = 0; k < 3; k++) cb("b_hold_099", 12'h099, 0, 0, 0, 1);
      cb("b_dec_098", 12'h098, 0, 0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
